processador_multiciclo_param: RTL and testbench

// - Parametrised multicycle processor: NREGS general registers of DATA_W bits, accumulator A, result register G, add/sub ALU.
// - Shared bus (BusWires) driven by one source per cycle.
// - Step counter T0..T3 sequences fetch/execute; control decodes IR and Tstep.
// - Top-level datapath of the lab system; instructions and immediates arrive on DIN.

---
 rtl/processador_multiciclo_param.sv | 171 +++++++++++++++++
 tb/tb_processador_multiciclo_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/processador_multiciclo_param.sv
// ============================================================================
// Module  : processador_multiciclo_param
// Purpose : Parametrised multicycle processor. It has NREGS general registers,
//           an accumulator A, a result register G and a small ALU, all on one
//           shared bus. A step counter T0..T3 sequences fetch and execute.
// Config  : define ALU_LOGIC_EN to execute opcodes 100 (and) and 101 (or) as
//           ALU operations. Without it they decode as reserved NOPs.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module processador_multiciclo_param #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires
);

  localparam int RA = $clog2(NREGS);
  localparam int IW = 3 + 2*RA;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  // An instruction word must fit in the datapath
  if (IW > DATA_W) begin : g_iw_check
    $error("instruction width IW exceeds DATA_W");
  end

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  tstep_e            step_q, step_d;
  logic [IW-1:0]     ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [2:0]        op;
  logic [RA-1:0]     rx;
  logic [RA-1:0]     ry;
  logic              is_alu;

  logic              ir_in, a_in, g_in, r_in;
  logic              din_out, g_out, r_out;
  logic [RA-1:0]     r_out_sel;
  logic [DATA_W-1:0] alu_res;

  assign op = ir_q[IW-1 -: 3];
  assign rx = ir_q[2*RA-1 -: RA];
  assign ry = ir_q[RA-1:0];

`ifdef ALU_LOGIC_EN
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
`else
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
`endif

  // Control decode: bus sources, register enables, Done and next step
  always_comb begin
    ir_in     = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    r_in      = 1'b0;
    din_out   = 1'b0;
    g_out     = 1'b0;
    r_out     = 1'b0;
    r_out_sel = ry;
    Done      = 1'b0;
    step_d    = step_q;
    case (step_q)
      T0: begin
        if (Run) begin
          ir_in  = 1'b1;
          step_d = T1;
        end
      end
      T1: begin
        if (op == OP_MV) begin
          r_out     = 1'b1;
          r_out_sel = ry;
          r_in      = 1'b1;
          Done      = 1'b1;
          step_d    = T0;
        end else if (op == OP_MVI) begin
          din_out = 1'b1;
          r_in    = 1'b1;
          Done    = 1'b1;
          step_d  = T0;
        end else if (is_alu) begin
          r_out     = 1'b1;
          r_out_sel = rx;
          a_in      = 1'b1;
          step_d    = T2;
        end else begin
          // Reserved opcode: complete as a NOP with an idle bus
          Done   = 1'b1;
          step_d = T0;
        end
      end
      T2: begin
        r_out     = 1'b1;
        r_out_sel = ry;
        g_in      = 1'b1;
        step_d    = T3;
      end
      T3: begin
        g_out  = 1'b1;
        r_in   = 1'b1;
        Done   = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase
  end

  // Bus multiplexer: only one source is enabled at a time by construction
  always_comb begin
    if (din_out)    BusWires = DIN;
    else if (g_out) BusWires = g_q;
    else if (r_out) BusWires = regs_q[r_out_sel];
    else            BusWires = '0;
  end

  // ALU: A op bus, modulo 2^DATA_W
  always_comb begin
    case (op)
      OP_SUB:  alu_res = a_q - BusWires;
`ifdef ALU_LOGIC_EN
      OP_AND:  alu_res = a_q & BusWires;
      OP_OR:   alu_res = a_q | BusWires;
`endif
      default: alu_res = a_q + BusWires;
    endcase
  end

  // Step counter and datapath registers; reset aborts any instruction in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      step_q <= step_d;
      if (ir_in) ir_q          <= DIN[IW-1:0];
      if (a_in)  a_q           <= BusWires;
      if (g_in)  g_q           <= alu_res;
      if (r_in)  regs_q[rx]    <= BusWires;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_processador_multiciclo_param.sv
// ============================================================================
// Module  : tb_processador_multiciclo_param
// Purpose : Self-checking bench for processador_multiciclo_param. An
//           instruction-level register model predicts Done and BusWires for
//           every cycle; register contents are read back through mv Rx,Rx.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processador_multiciclo_param;

  logic        clk = 1'b0;
  logic        rstn;
  logic        run;
  logic [15:0] din;
  logic        done;
  logic [15:0] bus;

  logic        run2;
  logic [7:0]  din2;
  logic        done2;
  logic [7:0]  bus2;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [15:0] mreg [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  processador_multiciclo_param #(.DATA_W(16), .NREGS(8)) u_dut (
    .Clock   (clk),
    .Resetn  (rstn),
    .Run     (run),
    .DIN     (din),
    .Done    (done),
    .BusWires(bus)
  );

  processador_multiciclo_param #(.DATA_W(8), .NREGS(4)) u_dut_narrow (
    .Clock   (clk),
    .Resetn  (rstn),
    .Run     (run2),
    .DIN     (din2),
    .Done    (done2),
    .BusWires(bus2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Execute one instruction on the wide instance, checking every cycle
  task automatic exec(input string name, input logic [2:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic [15:0] imm);
    logic        exp_done [4];
    logic [15:0] exp_bus  [4];
    logic [15:0] res;
    int          n;
    bit          alu;
    alu = (op == 3'd2) || (op == 3'd3);
`ifdef ALU_LOGIC_EN
    alu = alu || (op == 3'd4) || (op == 3'd5);
`endif
    exp_done[0] = 1'b0; exp_bus[0] = 16'h0;
    res = 16'h0;
    if (op == 3'd0) begin
      n = 2; exp_done[1] = 1'b1; exp_bus[1] = mreg[y]; res = mreg[y];
    end else if (op == 3'd1) begin
      n = 2; exp_done[1] = 1'b1; exp_bus[1] = imm; res = imm;
    end else if (alu) begin
      case (op)
        3'd2:    res = mreg[x] + mreg[y];
        3'd3:    res = mreg[x] - mreg[y];
        3'd4:    res = mreg[x] & mreg[y];
        default: res = mreg[x] | mreg[y];
      endcase
      n = 4;
      exp_done[1] = 1'b0; exp_bus[1] = mreg[x];
      exp_done[2] = 1'b0; exp_bus[2] = mreg[y];
      exp_done[3] = 1'b1; exp_bus[3] = res;
    end else begin
      n = 2; exp_done[1] = 1'b1; exp_bus[1] = 16'h0;
    end
    for (int c = 0; c < n; c++) begin
      if (c == 0) begin
        run = 1'b1;
        din = 16'($urandom);
        din[8:0] = {op, x, y};
      end else begin
        run = 1'($urandom_range(0, 1));
        din = (c == 1 && op == 3'd1) ? imm : 16'($urandom);
      end
      @(negedge clk);
      vectors++;
      if (done !== exp_done[c] || bus !== exp_bus[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: done=%b bus=%h, expected done=%b bus=%h",
                 name, c, done, bus, exp_done[c], exp_bus[c]);
      end
      @(posedge clk); #1;
    end
    if (op == 3'd0 || op == 3'd1 || alu) mreg[x] = res;
  endtask

  task automatic read_all(input string name);
    for (int r = 0; r < 8; r++) exec(name, 3'd0, 3'(r), 3'(r), 16'h0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; run = 1'b0; din = 16'h0; run2 = 1'b0; din2 = 8'h0;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || bus !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: done=%b bus=%h, expected done=0 bus=0000", done, bus);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    exec("reset_mvi1", 3'd1, 3'd1, 3'd0, 16'h1234);
    exec("reset_mvi2", 3'd1, 3'd2, 3'd0, 16'h0101);
    // Start add R1,R2 and abort it in the middle of T2
    run = 1'b1; din = {7'h0, 3'd2, 3'd1, 3'd2};
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    #2 rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || bus !== 16'h0) begin
      errors++;
      $display("FAIL reset_abort: done=%b bus=%h, expected done=0 bus=0000", done, bus);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    read_all("reset_regs");
  endtask

  task automatic test_mv();
    exec("mvi_r0", 3'd1, 3'd0, 3'd0, 16'd5);
    exec("mv_r1_r0", 3'd0, 3'd1, 3'd0, 16'h0);
    exec("rd_r0", 3'd0, 3'd0, 3'd0, 16'h0);
    exec("rd_r1", 3'd0, 3'd1, 3'd1, 16'h0);
  endtask

  task automatic test_add_wrap();
    exec("mvi_r2", 3'd1, 3'd2, 3'd0, 16'hFFFF);
    exec("mvi_r3", 3'd1, 3'd3, 3'd0, 16'h0001);
    exec("add_wrap", 3'd2, 3'd2, 3'd3, 16'h0);
    exec("rd_r2", 3'd0, 3'd2, 3'd2, 16'h0);
    exec("add_self", 3'd2, 3'd3, 3'd3, 16'h0);
  endtask

  task automatic test_sub();
    exec("mvi_r4", 3'd1, 3'd4, 3'd0, 16'd3);
    exec("mvi_r5", 3'd1, 3'd5, 3'd0, 16'd7);
    exec("sub_wrap", 3'd3, 3'd4, 3'd5, 16'h0);
    exec("rd_r4", 3'd0, 3'd4, 3'd4, 16'h0);
  endtask

  task automatic test_idle();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 16'($urandom);
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || bus !== 16'h0) begin
        errors++;
        $display("FAIL idle cycle %0d: done=%b bus=%h, expected done=0 bus=0000", i, done, bus);
      end
      @(posedge clk); #1;
    end
    read_all("idle_regs");
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    exec("b2b_0", 3'd1, 3'd5, 3'd0, 16'hA5A5);
    exec("b2b_1", 3'd1, 3'd6, 3'd0, 16'h5A5A);
    exec("b2b_2", 3'd1, 3'd7, 3'd0, 16'hC3C3);
    vectors++;
    if (cyc - start !== 6) begin
      errors++;
      $display("FAIL back_to_back: took %0d cycles, expected 6", cyc - start);
    end
  endtask

  task automatic test_logic();
    exec("mvi_r6", 3'd1, 3'd6, 3'd0, 16'h0F0F);
    exec("mvi_r7", 3'd1, 3'd7, 3'd0, 16'h00FF);
    exec("op100", 3'd4, 3'd6, 3'd7, 16'h0);
    exec("rd_r6", 3'd0, 3'd6, 3'd6, 16'h0);
    exec("op101", 3'd5, 3'd7, 3'd6, 16'h0);
    exec("rd_r7", 3'd0, 3'd7, 3'd7, 16'h0);
    exec("op110", 3'd6, 3'd1, 3'd2, 16'h0);
    exec("op111", 3'd7, 3'd3, 3'd4, 16'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      exec("random", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom));
    end
    read_all("random_regs");
  endtask

  // Narrow build (DATA_W=8, NREGS=4): mvi R0,#3; mvi R1,#7; sub R0,R1; mv R0,R0
  task automatic test_narrow();
    logic [6:0] code  [4];
    logic [7:0] imm   [4];
    logic [7:0] expb  [4];
    int         expn  [4];
    int         k;
    code[0] = {3'd1, 2'd0, 2'd0}; imm[0] = 8'd3; expb[0] = 8'd3;  expn[0] = 2;
    code[1] = {3'd1, 2'd1, 2'd0}; imm[1] = 8'd7; expb[1] = 8'd7;  expn[1] = 2;
    code[2] = {3'd3, 2'd0, 2'd1}; imm[2] = 8'd0; expb[2] = 8'hFC; expn[2] = 4;
    code[3] = {3'd0, 2'd0, 2'd0}; imm[3] = 8'd0; expb[3] = 8'hFC; expn[3] = 2;
    for (int i = 0; i < 4; i++) begin
      run2 = 1'b1; din2 = {1'b0, code[i]};
      @(posedge clk); #1;
      run2 = 1'b0; din2 = imm[i];
      k = 1;
      while (k <= 6) begin
        @(negedge clk);
        if (done2 === 1'b1) break;
        @(posedge clk); #1;
        k++;
      end
      vectors++;
      if (k + 1 !== expn[i] || bus2 !== expb[i]) begin
        errors++;
        $display("FAIL narrow instr %0d: cycles=%0d bus=%h, expected cycles=%0d bus=%h",
                 i, k + 1, bus2, expn[i], expb[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_mv();
    test_add_wrap();
    test_sub();
    test_idle();
    test_back_to_back();
    test_logic();
    test_random();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
